// File: rtl/jtag_pkg.sv
// Shared definitions for the DAP transfer sequencer and its jtagIF command interface.
package jtag_pkg;

    // Commands understood by the jtagIF pin engine
    typedef enum logic [1:0] {
        JTAG_CMD_IR     = 2'd0,
        JTAG_CMD_TFR    = 2'd1,
        JTAG_CMD_READID = 2'd2,
        JTAG_CMD_RESET  = 2'd3
    } jtag_cmd_e;

    // JTAG-DP instruction register values
    localparam logic [3:0] IR_DPACC  = 4'hA;
    localparam logic [3:0] IR_APACC  = 4'hB;
    localparam logic [3:0] IR_ABORT  = 4'h8;
    localparam logic [3:0] IR_IDCODE = 4'hE;

    // ACK codes returned by a DPACC/APACC scan
    localparam logic [2:0] ACK_OK   = 3'b010;
    localparam logic [2:0] ACK_WAIT = 3'b001;

    // DP RDBUFF register address bits [3:2]
    localparam logic [1:0] DP_ADDR_RDBUFF = 2'b11;

    // Request opcodes (op 3 behaves as a transfer)
    localparam logic [1:0] OP_TRANSFER = 2'd0;
    localparam logic [1:0] OP_READID   = 2'd1;
    localparam logic [1:0] OP_TAPRESET = 2'd2;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EVAL,
        S_DONE
    } seq_state_e;

    // Command currently in flight
    typedef enum logic [2:0] {
        STEP_IR_A,
        STEP_TFR_A,
        STEP_IR_B,
        STEP_TFR_B,
        STEP_READID,
        STEP_RESET
    } seq_step_e;

    // IR value a request needs selected before its first scan
    function automatic logic [3:0] needed_ir(input logic [1:0] op, input logic apndp);
        if (op == OP_READID) return IR_IDCODE;
        return apndp ? IR_APACC : IR_DPACC;
    endfunction

endpackage

// File: rtl/jtag_dap_seq.sv
// DAP transfer sequencer: turns one request into the jtagIF command sequence
// (IR select, DPACC/APACC scan with WAIT retries, RDBUFF follow-up) and caches
// the IR so repeated accesses to the same port skip the IR scan.
module jtag_dap_seq
    import jtag_pkg::*;
#(
    parameter int WAIT_RETRIES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_go,
    input  logic [1:0]  req_op,
    input  logic        req_apndp,
    input  logic        req_rnw,
    input  logic [1:0]  req_addr32,
    input  logic [31:0] req_dwrite,
    output logic        req_idle,
    output logic        rsp_valid,
    output logic [2:0]  rsp_ack,
    output logic [31:0] rsp_dread,
    output logic        j_go,
    output logic [1:0]  j_cmd,
    output logic [3:0]  j_ir,
    output logic        j_apndp,
    output logic        j_rnw,
    output logic [1:0]  j_addr32,
    output logic [31:0] j_dwrite,
    input  logic        j_idle,
    input  logic [2:0]  j_ack,
    input  logic [31:0] j_dread
);

    localparam int RETRY_W = $clog2(WAIT_RETRIES + 1);

    seq_state_e         state;
    seq_state_e         next_state;
    seq_step_e          step;
    jtag_cmd_e          cmd_q;
    logic [RETRY_W-1:0] retry_cnt;
    logic [3:0]         ir_cache;
    logic               ir_cache_valid;

    // Request fields captured at acceptance
    logic [1:0]         op_q;
    logic               apndp_q;
    logic               rnw_q;
    logic [1:0]         addr32_q;
    logic [31:0]        dwrite_q;

    // Per-cycle decisions taken in S_IDLE (accept) and S_EVAL (sequence)
    logic               launch;
    seq_step_e          launch_step;
    logic [3:0]         launch_ir;
    logic               retry_inc;
    logic               cache_load;
    logic [3:0]         cache_val;
    logic               finish;
    logic [2:0]         fin_ack;
    logic               fin_dread_load;

    logic [3:0]         need_req;
    logic [3:0]         need_q;
    logic               retry_ok;

    assign need_req = needed_ir(req_op, req_apndp);
    assign need_q   = needed_ir(op_q, apndp_q);
    assign retry_ok = (j_ack == ACK_WAIT) && (retry_cnt < RETRY_W'(WAIT_RETRIES));
    assign j_cmd    = cmd_q;

    // Choose the next jtagIF command, or completion, from the current step and result
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        launch         = 1'b0;
        launch_step    = STEP_IR_A;
        launch_ir      = need_q;
        retry_inc      = 1'b0;
        cache_load     = 1'b0;
        cache_val      = ir_cache;
        finish         = 1'b0;
        fin_ack        = ACK_OK;
        fin_dread_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_go) begin
                    launch    = 1'b1;
                    launch_ir = need_req;
                    if (req_op == OP_TAPRESET)
                        launch_step = STEP_RESET;
                    else if (ir_cache_valid && ir_cache == need_req)
                        launch_step = (req_op == OP_READID) ? STEP_READID : STEP_TFR_A;
                    else
                        launch_step = STEP_IR_A;
                end
            end
            S_EVAL: begin
                case (step)
                    STEP_IR_A: begin
                        cache_load  = 1'b1;
                        cache_val   = need_q;
                        launch      = 1'b1;
                        launch_step = (op_q == OP_READID) ? STEP_READID : STEP_TFR_A;
                    end
                    STEP_TFR_A, STEP_TFR_B: begin
                        if (retry_ok) begin
                            retry_inc   = 1'b1;
                            launch      = 1'b1;
                            launch_step = step;
                        end else if (j_ack != ACK_OK) begin
                            finish  = 1'b1;
                            fin_ack = j_ack;
                        end else if (step == STEP_TFR_A) begin
                            launch      = 1'b1;
                            launch_ir   = IR_DPACC;
                            launch_step = (ir_cache_valid && ir_cache == IR_APACC) ? STEP_IR_B
                                                                                    : STEP_TFR_B;
                        end else begin
                            finish         = 1'b1;
                            fin_dread_load = rnw_q;
                        end
                    end
                    STEP_IR_B: begin
                        cache_load  = 1'b1;
                        cache_val   = IR_DPACC;
                        launch      = 1'b1;
                        launch_step = STEP_TFR_B;
                    end
                    STEP_READID: begin
                        finish         = 1'b1;
                        fin_dread_load = 1'b1;
                    end
                    STEP_RESET: begin
                        cache_load = 1'b1;
                        cache_val  = IR_IDCODE;
                        finish     = 1'b1;
                    end
                    default: begin
                        finish  = 1'b1;
                        fin_ack = 3'b111;
                    end
                endcase
            end
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // FSM next-state: issue until jtagIF starts, wait until it is idle again, then evaluate
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (req_go) next_state = S_ISSUE;
            S_ISSUE: if (!j_idle) next_state = S_WAIT;
            S_WAIT:  if (j_idle)  next_state = S_EVAL;
            S_EVAL:  next_state = launch ? S_ISSUE : S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        j_go      = (state == S_ISSUE);
        req_idle  = (state == S_IDLE);
        rsp_valid = (state == S_DONE);
    end

    // Datapath: request capture, command fields, retry counter, IR cache, response
    always_ff @(posedge clk) begin
        if (rst) begin
            step           <= STEP_IR_A;
            cmd_q          <= JTAG_CMD_IR;
            j_ir           <= IR_IDCODE;
            j_apndp        <= 1'b0;
            j_rnw          <= 1'b0;
            j_addr32       <= 2'b00;
            j_dwrite       <= 32'h0;
            retry_cnt      <= '0;
            ir_cache       <= 4'h0;
            ir_cache_valid <= 1'b0;
            op_q           <= 2'b00;
            apndp_q        <= 1'b0;
            rnw_q          <= 1'b0;
            addr32_q       <= 2'b00;
            dwrite_q       <= 32'h0;
            rsp_ack        <= 3'b000;
            rsp_dread      <= 32'h0;
        end else begin
            if (state == S_IDLE && req_go) begin
                op_q     <= req_op;
                apndp_q  <= req_apndp;
                rnw_q    <= req_rnw;
                addr32_q <= req_addr32;
                dwrite_q <= req_dwrite;
            end

            if (launch) begin
                step <= launch_step;
                case (launch_step)
                    STEP_IR_A, STEP_IR_B: begin
                        cmd_q <= JTAG_CMD_IR;
                        j_ir  <= launch_ir;
                    end
                    STEP_TFR_A: begin
                        cmd_q <= JTAG_CMD_TFR;
                        if (state == S_IDLE) begin
                            j_apndp  <= req_apndp;
                            j_rnw    <= req_rnw;
                            j_addr32 <= req_addr32;
                            j_dwrite <= req_dwrite;
                        end else begin
                            j_apndp  <= apndp_q;
                            j_rnw    <= rnw_q;
                            j_addr32 <= addr32_q;
                            j_dwrite <= dwrite_q;
                        end
                    end
                    STEP_TFR_B: begin
                        cmd_q    <= JTAG_CMD_TFR;
                        j_apndp  <= 1'b0;
                        j_rnw    <= 1'b1;
                        j_addr32 <= DP_ADDR_RDBUFF;
                        j_dwrite <= 32'h0;
                    end
                    STEP_READID: cmd_q <= JTAG_CMD_READID;
                    default:     cmd_q <= JTAG_CMD_RESET;
                endcase
            end

            // Counter restarts at every new command except a WAIT reissue
            if (retry_inc)   retry_cnt <= retry_cnt + RETRY_W'(1);
            else if (launch) retry_cnt <= '0;

            if (cache_load) begin
                ir_cache       <= cache_val;
                ir_cache_valid <= 1'b1;
            end

            if (finish) begin
                rsp_ack <= fin_ack;
                if (fin_dread_load) rsp_dread <= j_dread;
            end
        end
    end

endmodule
